// File: rtl/d_reg_pipe_stage.sv
// d_reg_pipe_stage: one data register plus valid flag with load enable
module d_reg_pipe_stage #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] src,
  input  logic             src_v,
  output logic [WIDTH-1:0] dat,
  output logic             v
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v   <= 1'b0;
      dat <= RESET_VAL;
    end else if (clr) begin
      v   <= 1'b0;
      dat <= RESET_VAL;
    end else if (load) begin
      v <= src_v;
      if (src_v) dat <= src;
    end
endmodule

// File: rtl/d_reg_pipe.sv
// d_reg_pipe: WIDTH-bit, STAGES-deep bubble-collapsing register pipeline with
// valid/ready handshake on both ends and true/complement outputs.
module d_reg_pipe #(
  parameter int WIDTH = 8,
  parameter int STAGES = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic [WIDTH-1:0]             d,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             q,
  output logic [WIDTH-1:0]             q_bar,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);
  localparam int OW = $clog2(STAGES+1);
  logic [WIDTH-1:0]  dat [STAGES];
  logic [STAGES-1:0] v, load;
  logic              accept, pop;
  // A stage may load if any stage at or after it is empty, or the output drains.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    assign load[i] = out_ready | ~&v[STAGES-1:i];
    if (i == 0) begin : g_head
      d_reg_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .clk(clk), .reset(reset), .clr(clr), .load(load[i]),
        .src(d), .src_v(in_valid), .dat(dat[i]), .v(v[i])
      );
    end else begin : g_body
      d_reg_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .clk(clk), .reset(reset), .clr(clr), .load(load[i]),
        .src(dat[i-1]), .src_v(v[i-1]), .dat(dat[i]), .v(v[i])
      );
    end
  end
  assign q         = dat[STAGES-1];
  assign q_bar     = ~q;
  assign out_valid = v[STAGES-1];
  assign in_ready  = load[0] & ~clr & reset;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready & ~clr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) occupancy <= '0;
    else if (clr) occupancy <= '0;
    else if (accept & ~pop) occupancy <= occupancy + OW'(1);
    else if (pop & ~accept) occupancy <= occupancy - OW'(1);
endmodule

// File: tb/tb_d_reg_pipe.sv
// tb_d_reg_pipe: directed and random stimulus against a queue-based timing model
module tb_d_reg_pipe;
  localparam int S = 3;
  typedef struct { logic [7:0] data; int a; } ent_t;
  logic clk = 1'b0;
  logic reset, clr, in_valid, out_ready;
  logic [7:0] d;
  logic in_ready, out_valid;
  logic [7:0] q, q_bar;
  logic [1:0] occupancy;
  int errors = 0, checks = 0;
  ent_t qu[$];
  int ec, last_pop;
  logic [7:0] last_shown;
  bit acc;
  int idx;
  logic [7:0] words [5];

  d_reg_pipe #(.WIDTH(8), .STAGES(S), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .clr(clr), .d(d), .in_valid(in_valid),
    .in_ready(in_ready), .q(q), .q_bar(q_bar), .out_valid(out_valid),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A word reaches the output S-1 edges after acceptance, but never before its predecessor leaves.
  function automatic bit front_vis();
    int t;
    if (qu.size() == 0) return 1'b0;
    t = qu[0].a + S - 1;
    if (last_pop > t) t = last_pop;
    return ec >= t;
  endfunction

  task automatic model_reset();
    qu.delete();
    last_shown = 8'h00;
    last_pop = 0;
    ec = 0;
  endtask

  task automatic step(input logic c, input logic [7:0] dd, input logic iv, input logic ordy, output bit accepted);
    bit vis, eir, pop;
    logic [7:0] eq, eqb;
    @(negedge clk);
    clr = c; d = dd; in_valid = iv; out_ready = ordy;
    #1;
    vis = front_vis();
    eq  = vis ? qu[0].data : last_shown;
    eqb = ~eq;
    eir = !c && (qu.size() < S || ordy);
    chk("out_valid", out_valid, vis);
    chk("q", q, eq);
    chk("q_bar", q_bar, eqb);
    chk("in_ready", in_ready, eir);
    chk("occupancy", occupancy, 32'(qu.size()));
    accepted = iv && eir;
    pop = vis && ordy && !c;
    @(posedge clk);
    ec++;
    if (c) begin
      qu.delete();
      last_shown = 8'h00;
      last_pop = 0;
    end else begin
      if (pop) begin
        last_shown = qu[0].data;
        void'(qu.pop_front());
        last_pop = ec;
      end
      if (accepted) qu.push_back('{dd, ec});
    end
  endtask

  task automatic drain(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1, a);
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; d = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    #20;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q, 8'h00);
    chk("rst_q_bar", q_bar, 8'hFF);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_occupancy", occupancy, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    step(1'b0, 8'hA5, 1'b1, 1'b1, acc);
    step(1'b0, 8'h3C, 1'b1, 1'b1, acc);
    step(1'b0, 8'h0F, 1'b1, 1'b1, acc);
    drain(5);

    words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, words[idx], 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    #1;
    chk("fill_occ", occupancy, 3);
    chk("fill_accepted", idx, 3);
    for (int i = 0; i < 8 && idx < 5; i++) begin
      step(1'b0, words[idx], 1'b1, 1'b1, acc);
      if (acc) idx++;
    end
    drain(6);

    step(1'b0, 8'h10, 1'b1, 1'b0, acc);
    step(1'b0, 8'h11, 1'b1, 1'b0, acc);
    step(1'b0, 8'h12, 1'b1, 1'b0, acc);
    step(1'b0, 8'h13, 1'b1, 1'b1, acc);
    chk("pass_acc", acc, 1);
    #1;
    chk("pass_occ", occupancy, 3);
    chk("pass_q", q, 8'h11);
    drain(6);

    step(1'b0, 8'h20, 1'b1, 1'b0, acc);
    step(1'b0, 8'h21, 1'b1, 1'b0, acc);
    step(1'b1, 8'h77, 1'b1, 1'b0, acc);
    chk("clr_acc", acc, 0);
    #1;
    chk("clr_occ", occupancy, 0);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_q", q, 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);

    step(1'b0, 8'h31, 1'b1, 1'b0, acc);
    step(1'b0, 8'h32, 1'b1, 1'b0, acc);
    step(1'b0, 8'h33, 1'b1, 1'b0, acc);
    drain(0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("pre_rst_out_valid", out_valid, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_q", q, 8'h00);
    chk("mid_rst_q_bar", q_bar, 8'hFF);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_occ", occupancy, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 600; i++) begin
      logic c, iv, ordy;
      c    = ($urandom_range(31) == 0);
      iv   = ($urandom_range(3) != 0);
      ordy = (i < 300) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      step(c, 8'($urandom), iv, ordy, acc);
    end
    drain(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
